decoder_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one 3-to-8 decoder output bus among 8 requesters.

---
 rtl/dec_sched_pkg.sv | 28 ++
 rtl/decoder_rr_scheduler_rr_pick.sv | 37 +++
 rtl/decoder_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_decoder_rr_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | dec_sched_pkg : shared types and helpers for decoder_rr_scheduler         |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package dec_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] onehot(input sel_t s);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_rr_scheduler_rr_pick.sv
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin winner search starting at ptr        |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import dec_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             winner,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;

  // Rotating by ptr puts the highest-priority requester at bit 0.
  assign dbl     = {req, req};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[N_REQ-1:0];
  assign found   = |req;

  always_comb begin
    winner = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        winner = ptr + sel_t'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/decoder_rr_scheduler.sv
// +--------------------------------------------------------------------------+
// | decoder_rr_scheduler : round-robin owner of a shared 3-to-8 decoder bus  |
// | Optional hold timeout enabled by macro DEC_SCHED_TIMEOUT_EN.             |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_rr_scheduler
  import dec_sched_pkg::*;
`ifdef DEC_SCHED_TIMEOUT_EN
#(
  parameter int HOLD_MAX = 15,
  parameter int TMO_W    = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic             sel_valid,
  output logic             timeout_o
);

  state_t state;
  sel_t   sel;
  sel_t   ptr;
  sel_t   winner;
  logic   found;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  assign sel_a = sel[2];
  assign sel_b = sel[1];
  assign sel_c = sel[0];

`ifdef DEC_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] cnt;
  logic             tmo;

  assign timeout_o = tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      tmo       <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        GRANT: begin
          if (!req[sel]) begin
            state     <= GAP;
            gnt       <= '0;
            sel_valid <= 1'b0;
            ptr       <= sel + sel_t'(1);
          end else if (cnt == TMO_W'(HOLD_MAX - 1)) begin
            state     <= GAP;
            gnt       <= '0;
            sel_valid <= 1'b0;
            ptr       <= sel + sel_t'(1);
            tmo       <= 1'b1;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= onehot(winner);
            sel       <= winner;
            sel_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
`else
  assign timeout_o = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        GRANT: begin
          // Other agents' requests are ignored until the owner lets go.
          if (!req[sel]) begin
            state     <= GAP;
            gnt       <= '0;
            sel_valid <= 1'b0;
            ptr       <= sel + sel_t'(1);
          end
        end
        default: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= onehot(winner);
            sel       <= winner;
            sel_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_rr_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_decoder_rr_scheduler : directed + random bench with behavioural model |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decoder_rr_scheduler;

`ifdef DEC_SCHED_TIMEOUT_EN
  localparam int  HOLD   = 4;
  localparam bit  TMO_EN = 1'b1;
`else
  localparam int  HOLD   = 0;
  localparam bit  TMO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       sel_a, sel_b, sel_c, sel_valid, timeout_o;

  int checks = 0;
  int errors = 0;

`ifdef DEC_SCHED_TIMEOUT_EN
  decoder_rr_scheduler #(.HOLD_MAX(HOLD), .TMO_W(3)) dut (
`else
  decoder_rr_scheduler dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .sel_c     (sel_c),
    .sel_valid (sel_valid),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index or -1, rotating pointer, hold length.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1;
        end else if (TMO_EN && m_held == HOLD) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_tmo = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_sel   = m_owner;
            m_held  = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    check("sel_valid", int'(sel_valid), (m_owner >= 0) ? 1 : 0);
    check("sel", int'({sel_a, sel_b, sel_c}), m_sel);
    check("timeout_o", int'(timeout_o), int'(m_tmo));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (gnt != 8'h00) ok = 1'b1;
    end
    if (!ok) check("wait_gnt_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    logic [7:0] bitv;
    rst_n = 1'b0;
    req   = 8'hFF;
    #12;
    // Reset state with all requests high.
    check("rst_gnt", int'(gnt), 0);
    check("rst_sel_valid", int'(sel_valid), 0);
    check("rst_sel", int'({sel_a, sel_b, sel_c}), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_gnt", int'(gnt), 8'h01);
    check("first_sel", int'({sel_a, sel_b, sel_c}), 0);

    // Full rotation, each owner holds 3 cycles then releases.
    for (int i = 0; i <= 8; i++) begin
      bitv = 8'h01 << (i % 8);
      check("rot_gnt", int'(gnt), int'(bitv));
      repeat (2) @(negedge clk);
      check("rot_hold", int'(gnt), int'(bitv));
      #1 req = req & ~bitv;
      @(negedge clk);
      check("rot_gap", int'(gnt), 0);
      #1 req = req | bitv;
      @(negedge clk);
    end
    #1 req = 8'h00;
    repeat (3) tick();

    // Lone requester 5, release, then re-grant and wrap past 7.
    req = 8'h20;
    @(negedge clk);
    check("r5_gnt", int'(gnt), 8'h20);
    check("r5_sel", int'({sel_a, sel_b, sel_c}), 5);
    #1 req = 8'h00;
    @(negedge clk);
    check("r5_drop", int'(gnt), 0);
    #1 req = 8'h20;
    @(negedge clk);
    check("r5_again", int'(gnt), 8'h20);
    #1 req = 8'b0000_0101;
    @(negedge clk);
    check("wrap_gap", int'(gnt), 0);
    @(negedge clk);
    check("wrap_gnt", int'(gnt), 8'h01);
    check("wrap_sel", int'({sel_a, sel_b, sel_c}), 0);
    #1 req = 8'h00;
    repeat (2) tick();

    // Hold limit.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'h09;
    wait_gnt(5, ok);
    if (TMO_EN) begin
      for (int i = 0; i < HOLD; i++) begin
        check("tmo_hold", int'(gnt), 8'h01);
        if (i < HOLD - 1) @(negedge clk);
      end
      @(negedge clk);
      check("tmo_gap", int'(gnt), 0);
      check("tmo_pulse", int'(timeout_o), 1);
      @(negedge clk);
      check("tmo_next", int'(gnt), 8'h08);
      check("tmo_clear", int'(timeout_o), 0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        check("nohold_gnt", int'(gnt), 8'h01);
        @(negedge clk);
      end
    end

    // Asynchronous reset while an owner is granted.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_valid", int'(sel_valid), 0);
    tick();
    req = 8'hFF;
    rst_n = 1'b1;
    @(negedge clk);
    check("async_restart", int'(gnt), 8'h01);

    // Random traffic; owner tends to keep its request for a while.
    for (int c = 0; c < 3000; c++) begin
      tick();
      req = 8'($urandom & $urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    req = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
